// File: rtl/bam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : bam_ctrl_pkg
// Brief  : Shared kind codes, FSM states and field positions for bam_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package bam_ctrl_pkg;

    localparam int IMM_W = 16;

    localparam int KIND_HI  = 31;
    localparam int KIND_LO  = 29;
    localparam int SEL_HI   = 28;
    localparam int SEL_LO   = 26;
    localparam int RD_HI    = 25;
    localparam int RD_LO    = 21;
    localparam int RS1_HI   = 20;
    localparam int RS1_LO   = 16;
    localparam int RS2_HI   = 15;
    localparam int RS2_LO   = 11;
    localparam int MADDR_HI = 10;
    localparam int MADDR_LO = 6;

    // Kind codes are plain constants: 100-111 are illegal but must still be representable.
    localparam logic [2:0] C_KIND_NOP    = 3'b000;
    localparam logic [2:0] C_KIND_ALU_ST = 3'b001;
    localparam logic [2:0] C_KIND_CMP    = 3'b010;
    localparam logic [2:0] C_KIND_LDI    = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MEMWR = 3'd2,
        ST_FLAG  = 3'd3,
        ST_RFWR  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [2:0] kind_of(input logic [31:0] word);
        return word[KIND_HI:KIND_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bam_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module : bam_ctrl_decode
// Brief  : Combinational field split of the latched instruction word.
// Rev    : 1.0  initial release
// ============================================================================
module bam_ctrl_decode
    import bam_ctrl_pkg::*;
(
    input  logic [31:0] instr_q,
    output logic [2:0]  kind,
    output logic [2:0]  alu_sel,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  maddr,
    output logic [31:0] imm,
    output logic        illegal
);

    assign kind    = instr_q[KIND_HI:KIND_LO];
    assign alu_sel = instr_q[SEL_HI:SEL_LO];
    assign rd      = instr_q[RD_HI:RD_LO];
    assign rs1     = instr_q[RS1_HI:RS1_LO];
    assign rs2     = instr_q[RS2_HI:RS2_LO];
    assign maddr   = instr_q[MADDR_HI:MADDR_LO];
    assign imm     = {{(32-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};
    assign illegal = instr_q[KIND_HI];

endmodule
`default_nettype wire

// File: rtl/bam_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bam_ctrl
// Brief  : Multi-cycle sequencer driving the bam register file, ALU and RAM.
// Rev    : 1.0  initial release
// ============================================================================
module bam_ctrl
    import bam_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             done,
    output logic             err,
    output logic             zf_q,
    output logic [CNT_W-1:0] retired,
    output logic [4:0]       bam_ra1,
    output logic [4:0]       bam_ra2,
    output logic [2:0]       bam_sel,
    output logic [4:0]       bam_dir,
    output logic             bam_wr,
    output logic [4:0]       bam_dirb,
    output logic [31:0]      bam_di,
    output logic             bam_reg_write,
    input  logic             bam_zf
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_instr_q;
    logic             r_zf_q;
    logic [CNT_W-1:0] r_retired;

    logic [2:0]       w_kind;
    logic [2:0]       w_alu_sel;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_maddr;
    logic [31:0]      w_imm;
    logic             w_illegal;
    logic             w_accept;

    bam_ctrl_decode u_decode (
        .instr_q (r_instr_q),
        .kind    (w_kind),
        .alu_sel (w_alu_sel),
        .rd      (w_rd),
        .rs1     (w_rs1),
        .rs2     (w_rs2),
        .maddr   (w_maddr),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    assign w_accept = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The IDLE branch decodes the incoming word, since instr_q is only loaded on this edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (kind_of(instr))
                        C_KIND_ALU_ST, C_KIND_CMP: w_next = ST_READ;
                        C_KIND_LDI:                w_next = ST_RFWR;
                        default:                   w_next = ST_DONE;
                    endcase
                end
            end
            ST_READ: w_next = (w_kind == C_KIND_CMP) ? ST_FLAG : ST_MEMWR;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready   = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        bam_wr        = 1'b0;
        bam_reg_write = 1'b0;
        case (r_state)
            ST_IDLE:  instr_ready = 1'b1;
            ST_MEMWR: begin
                bam_wr = 1'b1;
                done   = 1'b1;
            end
            ST_FLAG:  done = 1'b1;
            ST_RFWR:  begin
                bam_reg_write = 1'b1;
                done          = 1'b1;
            end
            ST_DONE:  begin
                done = 1'b1;
                err  = w_illegal;
            end
            default:  instr_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_q <= '0;
            r_zf_q    <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_instr_q <= instr;
            end
            if (r_state == ST_MEMWR || r_state == ST_FLAG) begin
                r_zf_q <= bam_zf;
            end
            if (done) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Datapath fields come straight from instr_q so they hold until the next accept.
    assign bam_ra1  = w_rs1;
    assign bam_ra2  = w_rs2;
    assign bam_sel  = w_alu_sel;
    assign bam_dir  = w_maddr;
    assign bam_dirb = w_rd;
    assign bam_di   = w_imm;
    assign zf_q     = r_zf_q;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: doc/bam_ctrl.md
# bam_ctrl

Multi-cycle sequencer for the bam datapath (register file, ALU, RAM). Accepts one 32-bit instruction at a time over a valid/ready handshake and sequences it. It drives register read addresses, ALU selector, RAM address and write strobe, and register write address/data/strobe. It captures the datapath zero flag and reports completion, errors and a retired-instruction count.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- instr_valid  in  1  instruction present
- instr  in  32  instruction word
- instr_ready  out  1  controller can accept
- done  out  1  one-cycle pulse, instruction finished
- err  out  1  one-cycle pulse with done, illegal kind
- zf_q  out  1  registered zero flag of last ALU_ST/CMP
- retired  out  CNT_W  count of completed instructions, wraps
- bam_ra1, bam_ra2  out  5  register read addresses
- bam_sel  out  3  ALU operation select
- bam_dir  out  5  RAM address
- bam_wr  out  1  RAM write strobe
- bam_dirb  out  5  register write address
- bam_di  out  32  register write data
- bam_reg_write  out  1  register write strobe
- bam_zf  in  1  ALU zero flag

## Operation
- Instruction fields: kind[31:29], alu_sel[28:26], rd[25:21], rs1[20:16], rs2[15:11], maddr[10:6]; LDI immediate = instr[15:0], zero-extended to 32.
- Kinds: 000 NOP; 001 ALU_ST (ram[maddr] <- rs1 op rs2); 010 CMP (zf_q <- zf(rs1 op rs2), no store); 011 LDI (rf[rd] <- imm); 100-111 illegal.
- Accept when instr_valid && instr_ready; instr latched into instr_q. instr_ready = (state == IDLE).
- States: IDLE, READ, MEMWR, FLAG, RFWR, DONE.
- IDLE -> READ (ALU_ST, CMP), RFWR (LDI), DONE (NOP, illegal).
- READ -> MEMWR (ALU_ST) or FLAG (CMP). MEMWR, FLAG, RFWR, DONE -> IDLE.
- Datapath address/select/data outputs come from instr_q and stay stable from the cycle after accept until the cycle after the instruction returns to IDLE.
- bam_wr = 1 only in MEMWR. bam_reg_write = 1 only in RFWR.
- zf_q loads bam_zf in MEMWR and FLAG only.
- done = 1 in MEMWR, FLAG, RFWR, DONE. err = 1 in DONE when the kind is illegal.
- retired increments on every done, including illegal; it wraps at 2^CNT_W-1 -> 0.
- instr_valid while not ready is ignored; the word is not latched. The source must hold it.

## Timing
- Reset values: state IDLE, instr_q 0, all bam_* outputs 0, strobes 0, done/err 0, zf_q 0, retired 0, instr_ready 1.
- Reset mid-operation clears all outputs immediately (asynchronously). An in-flight write strobe drops in the same cycle.
- Latency from accept edge to the done cycle: LDI, NOP and illegal 1 cycle; ALU_ST and CMP 2 cycles.
- Next accept possible the cycle after done, so throughput is 1 instruction per 2 or 3 cycles.
- bam_zf is sampled at the end of MEMWR/FLAG, one full cycle after operands became stable.
- Strobes are exactly one cycle wide. Back-to-back LDIs produce no contiguous bam_reg_write.

## Structure
- Package bam_ctrl_pkg: kind codes, state enum, field bit positions, IMM_W = 16.
- Sub-module bam_ctrl_decode: combinational; instr_q -> kind, alu_sel, rd, rs1, rs2, maddr, imm, illegal. The FSM, counter and flag register stay in bam_ctrl.

## Test plan
- Reset, then LDI rd=3 imm=0x00A5 -> one cycle after accept: bam_reg_write=1, bam_dirb=3, bam_di=0x000000A5, done=1; retired=1.
- ALU_ST sel=010 rs1=1 rs2=2 maddr=7 -> READ cycle: bam_ra1=1, bam_ra2=2, bam_sel=010, bam_wr=0. Next cycle: bam_wr=1, bam_dir=7, done=1. zf_q = bam_zf driven in that cycle.
- CMP with bam_zf=1, then CMP with bam_zf=0 -> bam_wr and bam_reg_write never asserted; zf_q 1 then 0.
- kind=101 -> done=1 and err=1 in the same cycle, no strobes; retired increments.
- instr_valid held high with a continuous stream -> instr_ready low during busy cycles, no word skipped or duplicated. CNT_W=4 with 17 NOPs -> retired=1 after wrap.
- rst_n low during MEMWR -> bam_wr drops without waiting for clk; after release, state IDLE and retired=0.
